keccak_dom_rand_gen: RTL and testbench



---
 rtl/keccak_dom_pkg.sv | 19 +
 rtl/keccak_xorshift64_lane.sv | 41 ++++
 rtl/keccak_dom_rand_gen.sv | 100 ++++++++++
 tb/tb_keccak_dom_rand_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_dom_pkg.sv
// Shared definitions for the DOM Keccak fresh-randomness generator.
// Holds the random-bit count helper, the zero-seed replacement word and the FSM state type.
package keccak_dom_pkg;

    localparam logic [63:0] XS_SEED_FIX = 64'h9E3779B97F4A7C15;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        LOAD     = 2'd1,
        RUN      = 2'd2
    } rand_state_e;

    // One fresh bit per cross-share product pair, per Chi lane bit, per slice.
    function automatic int unsigned dom_rand_bits(input int unsigned shares,
                                                  input int unsigned slices);
        return ((shares * shares - shares) / 2) * 25 * slices;
    endfunction

endpackage

// File: rtl/keccak_xorshift64_lane.sv
// One 64-bit xorshift64 lane: loadable, steps once per enabled cycle, clears on reset.
module keccak_xorshift64_lane (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [63:0] seed_i,
    input  logic        step_i,
    output logic [63:0] lane_o
);

    logic [63:0] lane_d;
    logic [63:0] lane_q;

    function automatic logic [63:0] xs_step(input logic [63:0] x);
        logic [63:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    always_comb begin
        lane_d = lane_q;
        if (load_i) begin
            lane_d = seed_i;
        end else if (step_i) begin
            lane_d = xs_step(lane_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    assign lane_o = lane_q;

endmodule

// File: rtl/keccak_dom_rand_gen.sv
// Fresh-randomness producer for the masked Chi step: seeds xorshift64 lanes, then steps them per handshake.
// Optional KECCAK_RAND_ZERO_EN adds ZeroRandxSI to force ZxDO to zero for unprotected debug.
module keccak_dom_rand_gen
    import keccak_dom_pkg::*;
#(
    parameter  int unsigned SHARES = 2,
    parameter  int unsigned SLICES = 1,
    localparam int unsigned ZW     = dom_rand_bits(SHARES, SLICES)
) (
    input  logic          ClkxCI,
    input  logic          RstxRI,
    input  logic [63:0]   SeedxDI,
    input  logic          SeedValidxSI,
    output logic          SeedReadyxSO,
    input  logic          ReseedxSI,
    output logic [ZW-1:0] ZxDO,
    output logic          ZValidxSO,
    input  logic          ZReadyxSI
`ifdef KECCAK_RAND_ZERO_EN
    ,
    input  logic          ZeroRandxSI
`endif
);

    localparam int unsigned LANES = (ZW + 63) / 64;
    localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANES - 1);

    rand_state_e      state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             load_en;
    logic             step_en;
    logic [63:0]      seed_fixed;
    logic [64*LANES-1:0] lanes_flat;

    assign SeedReadyxSO = (state_q == LOAD);
    assign ZValidxSO    = (state_q == RUN);

    assign load_en    = SeedReadyxSO && SeedValidxSI && !ReseedxSI;
    assign step_en    = ZValidxSO && ZReadyxSI && !ReseedxSI;
    // A lane stuck at zero would never leave zero, so zero seeds are remapped per lane.
    assign seed_fixed = (SeedxDI == 64'd0) ? (XS_SEED_FIX ^ 64'(cnt_q)) : SeedxDI;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            UNSEEDED: state_d = LOAD;
            LOAD: begin
                if (load_en) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RUN:     state_d = RUN;
            default: state_d = UNSEEDED;
        endcase
        if (ReseedxSI) begin
            state_d = LOAD;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            state_q <= UNSEEDED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        keccak_xorshift64_lane u_lane (
            .clk_i  (ClkxCI),
            .rst_i  (RstxRI),
            .load_i (load_en && (cnt_q == CNT_W'(g))),
            .seed_i (seed_fixed),
            .step_i (step_en),
            .lane_o (lanes_flat[64*g +: 64])
        );
    end

    if (64 * LANES > ZW) begin : g_unused
        logic unused_lane_bits;
        assign unused_lane_bits = ^lanes_flat[64*LANES-1:ZW];
    end

`ifdef KECCAK_RAND_ZERO_EN
    assign ZxDO = ZeroRandxSI ? '0 : lanes_flat[ZW-1:0];
`else
    assign ZxDO = lanes_flat[ZW-1:0];
`endif

endmodule

// File: tb/tb_keccak_dom_rand_gen.sv
// Self-checking bench for keccak_dom_rand_gen: directed cases plus randomized traffic on two configurations.
module tb_keccak_dom_rand_gen;

    localparam logic [63:0] FIX = 64'h9E3779B97F4A7C15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    // Instance A: SHARES=2, SLICES=1 (25 bits, 1 lane); instance B: SHARES=3, SLICES=2 (150 bits, 3 lanes).
    logic [63:0]  seed_a = '0, seed_b = '0;
    logic         sv_a = 0, sv_b = 0, rs_a = 0, rs_b = 0, zr_a = 0, zr_b = 0;
    logic         sr_a, sr_b, zv_a, zv_b;
    logic [24:0]  z_a;
    logic [149:0] z_b;
    logic         zero_a = 0, zero_b = 0;

    keccak_dom_rand_gen #(.SHARES(2), .SLICES(1)) dut_a (
        .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed_a), .SeedValidxSI(sv_a),
        .SeedReadyxSO(sr_a), .ReseedxSI(rs_a), .ZxDO(z_a), .ZValidxSO(zv_a),
        .ZReadyxSI(zr_a)
`ifdef KECCAK_RAND_ZERO_EN
        , .ZeroRandxSI(zero_a)
`endif
    );

    keccak_dom_rand_gen #(.SHARES(3), .SLICES(2)) dut_b (
        .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed_b), .SeedValidxSI(sv_b),
        .SeedReadyxSO(sr_b), .ReseedxSI(rs_b), .ZxDO(z_b), .ZValidxSO(zv_b),
        .ZReadyxSI(zr_b)
`ifdef KECCAK_RAND_ZERO_EN
        , .ZeroRandxSI(zero_b)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 = waiting one cycle, 1 = collecting seeds, 2 = producing.
    int          m_mode [2];
    int          m_words[2];
    logic [63:0] m_lane [2][3];
    int          m_nl   [2] = '{1, 3};
    int          m_zw   [2] = '{25, 150};

    function automatic logic [63:0] xs(input logic [63:0] x);
        x = x ^ (x << 13);
        x = x ^ (x >> 7);
        x = x ^ (x << 17);
        return x;
    endfunction

    task automatic model_step(input int i, input logic r, input logic reseed,
                              input logic sv, input logic [63:0] seed, input logic zr);
        if (r) begin
            m_mode[i] = 0;
            m_words[i] = 0;
            for (int k = 0; k < 3; k++) m_lane[i][k] = '0;
        end else if (reseed) begin
            m_mode[i] = 1;
            m_words[i] = 0;
        end else if (m_mode[i] == 0) begin
            m_mode[i] = 1;
        end else if (m_mode[i] == 1) begin
            if (sv) begin
                m_lane[i][m_words[i]] = (seed == 64'd0) ? (FIX ^ 64'(m_words[i])) : seed;
                m_words[i]++;
                if (m_words[i] == m_nl[i]) begin
                    m_words[i] = 0;
                    m_mode[i] = 2;
                end
            end
        end else if (zr) begin
            for (int k = 0; k < m_nl[i]; k++) m_lane[i][k] = xs(m_lane[i][k]);
        end
    endtask

    function automatic logic [191:0] exp_z(input int i, input logic zero);
        logic [191:0] v;
        v = {m_lane[i][2], m_lane[i][1], m_lane[i][0]};
        v = v & ((192'd1 << m_zw[i]) - 192'd1);
`ifdef KECCAK_RAND_ZERO_EN
        if (zero) v = '0;
`else
        if (zero) v = v;
`endif
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(0, rst, rs_a, sv_a, seed_a, zr_a);
        model_step(1, rst, rs_b, sv_b, seed_b, zr_b);
        #1;
        chk("a_zvalid", 192'(zv_a), 192'(m_mode[0] == 2));
        chk("a_seedready", 192'(sr_a), 192'(m_mode[0] == 1));
        chk("a_z", 192'(z_a), exp_z(0, zero_a));
        chk("b_zvalid", 192'(zv_b), 192'(m_mode[1] == 2));
        chk("b_seedready", 192'(sr_b), 192'(m_mode[1] == 1));
        chk("b_z", 192'(z_b), exp_z(1, zero_b));
    endtask

    logic [24:0] held;
    int          sv_pat[7] = '{0, 1, 0, 0, 1, 0, 1};
    logic [63:0] b_words[3] = '{64'd1, 64'd2, 64'd3};

    initial begin
        int k;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_words[i] = 0;
            for (int j = 0; j < 3; j++) m_lane[i][j] = '0;
        end

        // Reset state
        tick();
        tick();
        chk("rst_zvalid_a", 192'(zv_a), 192'd0);
        chk("rst_z_a", 192'(z_a), 192'd0);
        chk("rst_seedready_a", 192'(sr_a), 192'd0);
        rst = 0;
        tick();
        chk("seedready_after_rst", 192'(sr_a), 192'd1);

        // Seed 1, then a single step
        seed_a = 64'd1; sv_a = 1;
        tick();
        sv_a = 0;
        chk("load1_z", 192'(z_a), 192'h0000001);
        chk("load1_zvalid", 192'(zv_a), 192'd1);
        zr_a = 1;
        tick();
        zr_a = 0;
        chk("step1_z", 192'(z_a), 192'h0822041);

`ifdef KECCAK_RAND_ZERO_EN
        zero_a = 1; zr_a = 1;
        tick();
        zr_a = 0;
        chk("zero_forced", 192'(z_a), 192'd0);
        chk("zero_zvalid", 192'(zv_a), 192'd1);
        zero_a = 0;
        tick();
        chk("zero_release", 192'(z_a), 192'(xs(64'h40822041)) & 192'h1FFFFFF);
`endif

        // Zero seed remap
        rs_a = 1;
        tick();
        rs_a = 0;
        chk("reseed_zvalid", 192'(zv_a), 192'd0);
        seed_a = 64'd0; sv_a = 1;
        tick();
        sv_a = 0;
        chk("zero_seed_z", 192'(z_a), 192'h14A7C15);

        // Hold, then reseed together with ZReady
        held = z_a;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold_z", 192'(z_a), 192'(held));
        end
        rs_a = 1; zr_a = 1;
        tick();
        rs_a = 0; zr_a = 0;
        chk("reseed_prio_zvalid", 192'(zv_a), 192'd0);
        chk("reseed_prio_seedready", 192'(sr_a), 192'd1);
        chk("reseed_prio_nostep", 192'(z_a), 192'(held));

        // Three lanes with gaps in SeedValid
        k = 0;
        for (int c = 0; c < 7; c++) begin
            sv_b = sv_pat[c][0];
            seed_b = sv_pat[c] != 0 ? b_words[k] : {$urandom, $urandom} | 64'd1;
            tick();
            if (sv_pat[c] != 0) k++;
            if (k < 3) chk("b_zvalid_wait", 192'(zv_b), 192'd0);
        end
        sv_b = 0;
        chk("b_zvalid_rise", 192'(zv_b), 192'd1);
        chk("b_lane0", 192'(z_b[63:0]), 192'd1);
        chk("b_lane1", 192'(z_b[127:64]), 192'd2);
        chk("b_lane2", 192'(z_b[149:128]), 192'd3);

        // Reset in the middle of seeding
        rs_b = 1;
        tick();
        rs_b = 0;
        sv_b = 1; seed_b = 64'h11;
        tick();
        seed_b = 64'h22;
        tick();
        sv_b = 0; rst = 1;
        tick();
        rst = 0;
        chk("midrst_zvalid", 192'(zv_b), 192'd0);
        chk("midrst_seedready", 192'(sr_b), 192'd0);
        chk("midrst_z", 192'(z_b), 192'd0);
        tick();
        sv_b = 1; seed_b = 64'h55;
        tick();
        seed_b = 64'h66;
        tick();
        seed_b = 64'h77;
        tick();
        sv_b = 0;
        chk("restart_lane0", 192'(z_b[63:0]), 192'h55);
        chk("restart_lane2", 192'(z_b[149:128]), 192'h77);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            rst    = ($urandom % 300) == 0;
            rs_a   = ($urandom % 50) == 0;
            rs_b   = ($urandom % 50) == 0;
            sv_a   = $urandom % 2;
            sv_b   = $urandom % 2;
            seed_a = ($urandom % 8 == 0) ? 64'd0 : {$urandom, $urandom};
            seed_b = ($urandom % 8 == 0) ? 64'd0 : {$urandom, $urandom};
            zr_a   = ($urandom % 3) != 0;
            zr_b   = ($urandom % 3) != 0;
`ifdef KECCAK_RAND_ZERO_EN
            zero_a = ($urandom % 10) == 0;
            zero_b = ($urandom % 10) == 0;
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
